// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one combinational-read instruction ROM between the core
// fetch port and a debug/loader port. Fetch has priority, a starvation counter
// bounds the debug wait, and a lock mode gives debug exclusive ownership.
module imem_arbiter #(
  parameter int unsigned SIZE       = 64,
  parameter int unsigned ADDR_W     = $clog2(SIZE),
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_owned,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [31:0]       rom_rd
);

  typedef enum logic {
    ARB     = 1'b0,
    DBG_OWN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  // Grant decision: forced debug grant on starvation, else fetch, else debug.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (state == DBG_OWN) begin
        dbg_gnt = dbg_req;
      end else if (dbg_req && (starve_cnt == CNT_MAX)) begin
        dbg_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  // ROM address follows the granted port; idle address is zero.
  always_comb begin
    rom_a = '0;
    if (if_gnt) begin
      rom_a = if_addr;
    end else if (dbg_gnt) begin
      rom_a = dbg_addr;
    end
  end

  // Ownership state: lock level selects the mode for the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      dbg_owned <= 1'b0;
    end else begin
      state     <= dbg_lock ? DBG_OWN : ARB;
      dbg_owned <= dbg_lock;
    end
  end

  // Starvation counter: counts consecutive refusals of a pending debug request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if ((state == DBG_OWN) || dbg_gnt || !dbg_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Fetch read data: captured one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) begin
        if_rdata <= rom_rd;
      end
    end
  end

  // Debug read data: captured one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_rdata <= rom_rd;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed testbench for imem_arbiter with a behavioural ROM.
module tb_imem_arbiter;

  localparam int unsigned SIZE   = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              dbg_owned;
  logic [ADDR_W-1:0] rom_a;
  logic [31:0]       rom_rd;

  int checks;
  int failures;

  imem_arbiter #(.SIZE(SIZE), .ADDR_W(ADDR_W), .STARVE_MAX(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_lock(dbg_lock),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_owned(dbg_owned), .rom_a(rom_a), .rom_rd(rom_rd)
  );

  // Distinct contents per word so wrong-address reads are visible.
  function automatic logic [31:0] rom_f(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = {2'b00, a};
    return {8'hC3, b, b ^ 8'h5A, 8'(b * 8'd3)};
  endfunction

  assign rom_rd = rom_f(rom_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller holds if_req=1 with cnt at 0: three refusals, then forced debug grant.
  task automatic starve_run(input string tag, input logic [ADDR_W-1:0] a);
    dbg_req  = 1'b1;
    dbg_addr = a;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk({tag, "_if_gnt"}, 32'(if_gnt), 32'd1);
      chk({tag, "_dbg_refused"}, 32'(dbg_gnt), 32'd0);
      tick();
    end
    #1;
    chk({tag, "_dbg_gnt"}, 32'(dbg_gnt), 32'd1);
    chk({tag, "_if_blocked"}, 32'(if_gnt), 32'd0);
    chk({tag, "_rom_a"}, 32'(rom_a), 32'(a));
    tick();
    dbg_req = 1'b0;
    chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'd1);
    chk({tag, "_dbg_rdata"}, dbg_rdata, rom_f(a));
    chk({tag, "_if_rvalid_gap"}, 32'(if_rvalid), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    dbg_req  = 1'b0;
    dbg_addr = '0;
    dbg_lock = 1'b0;

    // Reset state
    #12;
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_dbg_owned", 32'(dbg_owned), 32'd0);
    chk("rst_gnts", 32'({if_gnt, dbg_gnt}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fetch only, addresses 5,6,7
    if_req = 1'b1;
    for (int a = 5; a <= 7; a++) begin
      if_addr = ADDR_W'(a);
      #1;
      chk("fetch_if_gnt", 32'(if_gnt), 32'd1);
      chk("fetch_rom_a", 32'(rom_a), 32'(a));
      tick();
      chk("fetch_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("fetch_if_rdata", if_rdata, rom_f(ADDR_W'(a)));
      chk("fetch_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    end
    if_req = 1'b0;
    #1;
    chk("idle_rom_a", 32'(rom_a), 32'd0);
    tick();
    chk("idle_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("idle_if_rdata_hold", if_rdata, rom_f(6'd7));

    // Contention: fetch and debug both held high
    if_req  = 1'b1;
    if_addr = 6'd9;
    starve_run("contend", 6'd20);

    // Idle fetch: debug granted immediately, twice in a row
    if_req   = 1'b0;
    dbg_req  = 1'b1;
    dbg_addr = 6'd33;
    #1;
    chk("dbgidle_gnt0", 32'(dbg_gnt), 32'd1);
    chk("dbgidle_rom_a0", 32'(rom_a), 32'd33);
    tick();
    chk("dbgidle_rvalid0", 32'(dbg_rvalid), 32'd1);
    chk("dbgidle_rdata0", dbg_rdata, rom_f(6'd33));
    dbg_addr = 6'd34;
    #1;
    chk("dbgidle_gnt1", 32'(dbg_gnt), 32'd1);
    tick();
    chk("dbgidle_rvalid1", 32'(dbg_rvalid), 32'd1);
    chk("dbgidle_rdata1", dbg_rdata, rom_f(6'd34));
    // Counter stayed 0: a full wait is needed again
    if_req = 1'b1;
    starve_run("after_idle", 6'd35);

    // Drop-before-grant: two refusals, one idle cycle, then a full wait
    dbg_req  = 1'b1;
    dbg_addr = 6'd50;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_refused", 32'(dbg_gnt), 32'd0);
      tick();
    end
    dbg_req = 1'b0;
    tick();
    starve_run("after_drop", 6'd51);

    // Lock: rising cycle still arbitrates, then debug owns the ROM
    if_addr  = 6'd11;
    dbg_lock = 1'b1;
    #1;
    chk("lock_c0_if_gnt", 32'(if_gnt), 32'd1);
    chk("lock_c0_owned", 32'(dbg_owned), 32'd0);
    tick();
    chk("lock_c0_if_rvalid", 32'(if_rvalid), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      dbg_req  = 1'b1;
      dbg_addr = ADDR_W'(40 + i);
      #1;
      chk("lock_owned", 32'(dbg_owned), 32'd1);
      chk("lock_if_gnt", 32'(if_gnt), 32'd0);
      chk("lock_dbg_gnt", 32'(dbg_gnt), 32'd1);
      tick();
      chk("lock_dbg_rdata", dbg_rdata, rom_f(ADDR_W'(40 + i)));
    end
    dbg_req  = 1'b0;
    dbg_lock = 1'b0;
    #1;
    chk("unlock_cN_owned", 32'(dbg_owned), 32'd1);
    chk("unlock_cN_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    chk("unlock_cN1_owned", 32'(dbg_owned), 32'd0);
    chk("unlock_cN1_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    chk("unlock_if_rdata", if_rdata, rom_f(6'd11));

    // Reset mid-run with a pending fetch response and lock held
    if_addr  = 6'd13;
    dbg_lock = 1'b1;
    tick();
    chk("prerst_if_rvalid", 32'(if_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);
    chk("midrst_owned", 32'(dbg_owned), 32'd0);
    chk("midrst_if_gnt", 32'(if_gnt), 32'd0);
    chk("midrst_rom_a", 32'(rom_a), 32'd0);
    dbg_lock = 1'b0;
    tick();
    @(negedge clk);
    rst_n   = 1'b1;
    if_addr = 6'd14;
    #1;
    chk("postrst_if_gnt", 32'(if_gnt), 32'd1);
    tick();
    chk("postrst_if_rdata", if_rdata, rom_f(6'd14));
    if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
